srl_fifo_ctrl: RTL and testbench

- Controller that turns a 32-word x W-bit addressable shift register into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits between DSP pipeline stages, e.g. decimator output to modulator input, where cheap SRL-based buffering replaces block RAM.
- Generates the storage shift-enable and read address from an occupancy counter, and adds one registered output word for timing.

---
 rtl/srl_fifo_ctrl_pkg.sv | 12 +
 rtl/srl_store_wx32.sv | 27 ++
 rtl/srl_fifo_ctrl.sv | 98 +++++++++
 tb/tb_srl_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_fifo_ctrl_pkg.sv
// rtl/srl_fifo_ctrl_pkg.sv - shared constants for SRL-based DSP buffering
package srl_fifo_ctrl_pkg;

  localparam int SRL_ADDR_W = 5;
  localparam int SRL_DEPTH  = 2 ** SRL_ADDR_W;

  // Occupancy includes the output register, so it needs one bit beyond the address.
  function automatic int level_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/srl_store_wx32.sv
// rtl/srl_store_wx32.sv - W-bit wide, 32-deep addressable shift register
module srl_store_wx32
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                  i_clk,
  input  logic [W-1:0]          i_d,
  input  logic [SRL_ADDR_W-1:0] i_a,
  input  logic                  i_ce,
  output logic [W-1:0]          o_q
);

  // One SRL32 per bit: new data enters at address 0, no reset on the contents.
  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [SRL_DEPTH-1:0] r_srl;

    always_ff @(posedge i_clk) begin
      if (i_ce) begin
        r_srl <= {r_srl[SRL_DEPTH-2:0], i_d[b]};
      end
    end

    assign o_q[b] = r_srl[i_a];
  end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// rtl/srl_fifo_ctrl.sv - first-word-fall-through FIFO controller over an SRL32 store
module srl_fifo_ctrl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int W        = 4,
  parameter int ADDR_W   = SRL_ADDR_W,
  parameter int AF_LEVEL = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [level_w(ADDR_W)-1:0] level,
  output logic                       almost_full
);

  localparam int LW = level_w(ADDR_W);
  localparam logic [LW-1:0] DEPTH_C = LW'(2 ** ADDR_W);
  localparam logic [LW-1:0] AF_C    = LW'(AF_LEVEL);

  logic [LW-1:0]     r_count;
  logic [W-1:0]      r_out_data;
  logic              r_out_valid;
  logic [LW-1:0]     r_level;
  logic              r_almost_full;

  logic              w_push;
  logic              w_load;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [W-1:0]      w_store_q;
  logic [LW-1:0]     w_count_nxt;
  logic              w_out_valid_nxt;
  logic [LW-1:0]     w_level_nxt;

  assign in_ready  = !rst && (r_count != DEPTH_C);
  assign w_push    = in_valid && in_ready;
  assign w_load    = (r_count != '0) && (!r_out_valid || out_ready);
  // At count == DEPTH the low bits wrap to 0, so the decrement lands on 31 as needed.
  assign w_rd_addr = (r_count != '0) ? (r_count[ADDR_W-1:0] - ADDR_W'(1)) : '0;

  srl_store_wx32 #(
    .W (W)
  ) u_store (
    .i_clk (clk),
    .i_d   (in_data),
    .i_a   (w_rd_addr),
    .i_ce  (w_push),
    .o_q   (w_store_q)
  );

  always_comb begin
    w_count_nxt     = r_count;
    w_out_valid_nxt = r_out_valid;
    if (w_push && !w_load) begin
      w_count_nxt = r_count + LW'(1);
    end else if (w_load && !w_push) begin
      w_count_nxt = r_count - LW'(1);
    end
    if (w_load) begin
      w_out_valid_nxt = 1'b1;
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
    if (rst) begin
      w_count_nxt     = '0;
      w_out_valid_nxt = 1'b0;
    end
    w_level_nxt = w_count_nxt + LW'(w_out_valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_count       <= w_count_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_level       <= w_level_nxt;
      r_almost_full <= (w_level_nxt >= AF_C);
      if (w_load) begin
        r_out_data <= w_store_q;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign level       = r_level;
  assign almost_full = r_almost_full;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb/tb_srl_fifo_ctrl.sv - directed and scoreboarded bench for srl_fifo_ctrl
module tb_srl_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] level;
  logic       almost_full;

  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  srl_fifo_ctrl #(
    .W        (4),
    .ADDR_W   (5),
    .AF_LEVEL (28)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  // Drives one cycle of inputs and reports what handshakes happened; no checking here.
  task automatic do_cycle(input logic v, input logic [3:0] d, input logic r,
                          output logic pushed, output logic popped, output logic [3:0] pd);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    pushed = in_valid & in_ready;
    popped = out_valid & out_ready;
    pd     = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 4'h3; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (level !== 6'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (level !== 6'd0 || out_valid !== 1'b0 || out_data !== 4'h0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got level=%0d ov=%b od=%h af=%b expected 0 0 0 0", level, out_valid, out_data, almost_full);
    end
  endtask

  task automatic test_single();
    logic pu, po;
    logic [3:0] pd;
    do_cycle(1'b1, 4'hA, 1'b1, pu, po, pd);
    checks++;
    if (out_valid !== 1'b0 || level !== 6'd1) begin
      errors++; $display("FAIL single_c1: got ov=%b level=%0d expected 0 1", out_valid, level);
    end
    do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || level !== 6'd1) begin
      errors++; $display("FAIL single_c2: got ov=%b od=%h level=%0d expected 1 a 1", out_valid, out_data, level);
    end
    do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
    checks++;
    if (po !== 1'b1 || pd !== 4'hA) begin
      errors++; $display("FAIL single_pop: got popped=%b data=%h expected 1 a", po, pd);
    end
    checks++;
    if (out_valid !== 1'b0 || level !== 6'd0) begin
      errors++; $display("FAIL single_empty: got ov=%b level=%0d expected 0 0", out_valid, level);
    end
  endtask

  task automatic test_fill();
    logic pu, po;
    logic [3:0] pd;
    int idx;
    for (int i = 0; i < 33; i++) begin
      do_cycle(1'b1, 4'(i), 1'b0, pu, po, pd);
      checks++;
      if (pu !== 1'b1) begin errors++; $display("FAIL fill_accept[%0d]: got %b expected 1", i, pu); end
      if (pu) q.push_back(4'(i));
      checks++;
      if (level !== 6'(i + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level, i + 1); end
      checks++;
      if (almost_full !== (i + 1 >= 28)) begin
        errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 28));
      end
    end
    do_cycle(1'b1, 4'hF, 1'b0, pu, po, pd);
    checks++;
    if (pu !== 1'b0 || level !== 6'd33) begin
      errors++; $display("FAIL fill_overflow: got pushed=%b level=%0d expected 0 33", pu, level);
    end
    idx = 0;
    for (int k = 0; k < 100 && idx < 33; k++) begin
      do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
      if (po) begin
        checks++;
        if (pd !== 4'(idx)) begin errors++; $display("FAIL fill_order[%0d]: got %h expected %h", idx, pd, 4'(idx)); end
        idx++;
        void'(q.pop_front());
      end
    end
    checks++;
    if (idx != 33 || level !== 6'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL fill_drain: got words=%0d level=%0d ov=%b expected 33 0 0", idx, level, out_valid);
    end
  endtask

  task automatic test_full_stream();
    logic pu, po;
    logic [3:0] pd, exp;
    int n;
    for (int i = 0; i < 33; i++) begin
      do_cycle(1'b1, 4'(i * 3), 1'b0, pu, po, pd);
      if (pu) q.push_back(4'(i * 3));
    end
    checks++;
    if (level !== 6'd33) begin errors++; $display("FAIL full_level: got %0d expected 33", level); end
    for (int c = 0; c < 40; c++) begin
      do_cycle(1'b1, 4'(c + 7), 1'b1, pu, po, pd);
      checks++;
      if (pu !== (c != 0) || po !== 1'b1) begin
        errors++; $display("FAIL full_hs[%0d]: got pushed=%b popped=%b expected %b 1", c, pu, po, (c != 0));
      end
      if (po) begin
        exp = q.pop_front();
        checks++;
        if (pd !== exp) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", c, pd, exp); end
      end
      if (pu) q.push_back(4'(c + 7));
      checks++;
      if (level !== 6'(q.size())) begin errors++; $display("FAIL full_lvl[%0d]: got %0d expected %0d", c, level, q.size()); end
    end
    for (int k = 0; k < 100 && q.size() > 16; k++) begin
      do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
      if (po) begin
        exp = q.pop_front();
        checks++;
        if (pd !== exp) begin errors++; $display("FAIL half_drain: got %h expected %h", pd, exp); end
      end
    end
    for (int c = 0; c < 30; c++) begin
      do_cycle(1'b1, 4'(c), 1'b1, pu, po, pd);
      checks++;
      if (pu !== 1'b1 || po !== 1'b1) begin
        errors++; $display("FAIL stream_rate[%0d]: got pushed=%b popped=%b expected 1 1", c, pu, po);
      end
      if (po) begin
        exp = q.pop_front();
        checks++;
        if (pd !== exp) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", c, pd, exp); end
      end
      if (pu) q.push_back(4'(c));
      checks++;
      if (level !== 6'd16) begin errors++; $display("FAIL stream_level[%0d]: got %0d expected 16", c, level); end
    end
    n = 0;
    for (int k = 0; k < 100 && q.size() > 0; k++) begin
      do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
      if (po) begin
        exp = q.pop_front();
        checks++;
        if (pd !== exp) begin errors++; $display("FAIL stream_drain[%0d]: got %h expected %h", n, pd, exp); end
        n++;
      end
    end
    checks++;
    if (q.size() != 0 || level !== 6'd0) begin
      errors++; $display("FAIL stream_empty: got left=%0d level=%0d expected 0 0", q.size(), level);
    end
  endtask

  task automatic test_random();
    logic pu, po, v, r, hold;
    logic [3:0] pd, d, held, exp;
    int sent, cyc;
    sent = 0; cyc = 0; hold = 1'b0; held = 4'h0;
    while ((sent < 2000 || q.size() != 0) && cyc < 20000) begin
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL rand_stable[%0d]: got ov=%b od=%h expected 1 %h", cyc, out_valid, out_data, held);
        end
      end
      v = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = 1'($urandom_range(0, 1));
      d = 4'($urandom);
      hold = out_valid & ~r;
      held = out_data;
      do_cycle(v, d, r, pu, po, pd);
      if (po) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious[%0d]: got word %h expected none", cyc, pd);
        end else begin
          exp = q.pop_front();
          if (pd !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", cyc, pd, exp); end
        end
      end
      if (pu) begin
        q.push_back(d);
        sent++;
      end
      checks++;
      if (level !== 6'(q.size())) begin errors++; $display("FAIL rand_level[%0d]: got %0d expected %0d", cyc, level, q.size()); end
      cyc++;
    end
    checks++;
    if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected under 20000", cyc); end
  endtask

  task automatic test_reset_mid();
    logic pu, po;
    logic [3:0] pd;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 4'(9 - i), 1'b0, pu, po, pd);
    end
    checks++;
    if (level !== 6'd10) begin errors++; $display("FAIL mid_level: got %0d expected 10", level); end
    rst = 1'b1; in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    checks++;
    if (level !== 6'd0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got level=%0d ov=%b af=%b expected 0 0 0", level, out_valid, almost_full);
    end
    do_cycle(1'b1, 4'h5, 1'b1, pu, po, pd);
    checks++;
    if (pu !== 1'b1 || out_valid !== 1'b0 || level !== 6'd1) begin
      errors++; $display("FAIL mid_push: got pushed=%b ov=%b level=%0d expected 1 0 1", pu, out_valid, level);
    end
    do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      errors++; $display("FAIL mid_first: got ov=%b od=%h expected 1 5", out_valid, out_data);
    end
    do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || level !== 6'd0) begin
        errors++; $display("FAIL mid_stale[%0d]: got ov=%b level=%0d expected 0 0", i, out_valid, level);
      end
      do_cycle(1'b0, 4'h0, 1'b1, pu, po, pd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_stream();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
